// File: rtl/positron_layer_serializer_pkg.sv
// Shared helpers for the positron layer datapath.
// log2() gives index widths for word counters, never narrower than one bit.
package posit_defines;

  function automatic int log2(input int value);
    int res;
    res = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        res = i + 1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/positron_layer_serializer_bank.sv
// One frame buffer: captures a whole layer output in one write,
// then presents the word selected by rd_idx.
module layer_frame_bank
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH  = 4,
  parameter int NB_POSITRONS = 16,
  localparam int IDX_W       = log2(NB_POSITRONS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                we,
  input  logic [NB_POSITRONS*POSIT_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]                    rd_idx,
  output logic [POSIT_WIDTH-1:0]              rdata
);

  logic [NB_POSITRONS-1:0][POSIT_WIDTH-1:0] mem_r;

  // bank storage, whole frame written at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r <= '0;
    end else if (we) begin
      mem_r <= wdata;
    end else begin
      mem_r <= mem_r;
    end
  end

  // word select; compare-based so a one-word bank needs no special casing
  always_comb begin
    rdata = {POSIT_WIDTH{1'b0}};
    for (int i = 0; i < NB_POSITRONS; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        rdata = mem_r[i];
      end else begin
        rdata = rdata;
      end
    end
  end

endmodule

// File: rtl/positron_layer_serializer.sv
// Collects a lock-stepped layer's parallel outputs into a ping-pong buffer
// and re-emits each frame as a serial posit stream with sow/eow markers.
module positron_layer_serializer
  import posit_defines::*;
#(
  parameter int POSIT_WIDTH  = 4,
  parameter int NB_POSITRONS = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  output logic                                rtr_o,
  input  logic [NB_POSITRONS-1:0]             rts_i,
  input  logic [NB_POSITRONS-1:0]             eow_i,
  input  logic [NB_POSITRONS*POSIT_WIDTH-1:0] posit_i,
  input  logic                                rtr_i,
  output logic                                rts_o,
  output logic                                sow_o,
  output logic                                eow_o,
  output logic [POSIT_WIDTH-1:0]              posit_o
);

  localparam int IDX_W = log2(NB_POSITRONS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_POSITRONS - 1);

  logic [1:0]             bank_full_r, bank_full_s;
  logic                   wr_sel_r, wr_sel_s;
  logic                   rd_sel_r, rd_sel_s;
  logic [IDX_W-1:0]       idx_r, idx_s;
  logic                   partial_seen;
  logic                   cap_s, xfer_s, last_s, partial_s;
  logic [POSIT_WIDTH-1:0] rdata0_s, rdata1_s;
  logic                   eow_unused_s;

  // positrons only raise rts with eow, so eow_i carries no extra information
  assign eow_unused_s = ^eow_i;

  assign rtr_o     = ~bank_full_r[wr_sel_r];
  assign rts_o     = bank_full_r[rd_sel_r];
  assign cap_s     = rtr_o & (&rts_i);
  assign partial_s = (|rts_i) & ~(&rts_i);
  assign xfer_s    = rts_o & rtr_i;
  assign last_s    = (idx_r == IDX_LAST);

  layer_frame_bank #(
    .POSIT_WIDTH  (POSIT_WIDTH),
    .NB_POSITRONS (NB_POSITRONS)
  ) u_bank0 (
    .clk    (clk),
    .rst    (rst),
    .we     (cap_s & ~wr_sel_r),
    .wdata  (posit_i),
    .rd_idx (idx_r),
    .rdata  (rdata0_s)
  );

  layer_frame_bank #(
    .POSIT_WIDTH  (POSIT_WIDTH),
    .NB_POSITRONS (NB_POSITRONS)
  ) u_bank1 (
    .clk    (clk),
    .rst    (rst),
    .we     (cap_s & wr_sel_r),
    .wdata  (posit_i),
    .rd_idx (idx_r),
    .rdata  (rdata1_s)
  );

  // next-state for buffer control; capture and release may hit both banks in one cycle
  always_comb begin
    bank_full_s = bank_full_r;
    wr_sel_s    = wr_sel_r;
    rd_sel_s    = rd_sel_r;
    idx_s       = idx_r;
    if (cap_s) begin
      bank_full_s[wr_sel_r] = 1'b1;
      wr_sel_s              = ~wr_sel_r;
    end else begin
      wr_sel_s = wr_sel_r;
    end
    if (xfer_s && last_s) begin
      bank_full_s[rd_sel_r] = 1'b0;
      rd_sel_s              = ~rd_sel_r;
      idx_s                 = {IDX_W{1'b0}};
    end else if (xfer_s) begin
      idx_s = idx_r + IDX_W'(1);
    end else begin
      idx_s = idx_r;
    end
  end

  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full_r <= 2'b00;
      wr_sel_r    <= 1'b0;
      rd_sel_r    <= 1'b0;
      idx_r       <= {IDX_W{1'b0}};
    end else begin
      bank_full_r <= bank_full_s;
      wr_sel_r    <= wr_sel_s;
      rd_sel_r    <= rd_sel_s;
      idx_r       <= idx_s;
    end
  end

  // sticky flag for a layer that fell out of lock-step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      partial_seen <= 1'b0;
    end else if (partial_s) begin
      partial_seen <= 1'b1;
    end else begin
      partial_seen <= partial_seen;
    end
  end

  // serial output, zeroed whenever no word is offered
  always_comb begin
    posit_o = {POSIT_WIDTH{1'b0}};
    sow_o   = 1'b0;
    eow_o   = 1'b0;
    if (rts_o) begin
      posit_o = rd_sel_r ? rdata1_s : rdata0_s;
      sow_o   = (idx_r == {IDX_W{1'b0}});
      eow_o   = last_s;
    end else begin
      posit_o = {POSIT_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Directed bench: a 4-word instance for framing/backpressure/reset cases
// and a 1-word instance for the single-beat frame and throughput case.
module tb_positron_layer_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        rtr4, rts4, sow4, eow4, rtr_i4;
  logic [3:0]  rts_i4, eow_i4, posit4;
  logic [15:0] posit_i4;

  logic        rtr1, rts1, sow1, eow1, rtr_i1, rts_i1;
  logic [3:0]  posit1, posit_i1;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRONS(4)) u_dut4 (
    .clk(clk), .rst(rst), .rtr_o(rtr4), .rts_i(rts_i4), .eow_i(eow_i4),
    .posit_i(posit_i4), .rtr_i(rtr_i4), .rts_o(rts4), .sow_o(sow4),
    .eow_o(eow4), .posit_o(posit4)
  );

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRONS(1)) u_dut1 (
    .clk(clk), .rst(rst), .rtr_o(rtr1), .rts_i(rts_i1), .eow_i(rts_i1),
    .posit_i(posit_i1), .rtr_i(rtr_i1), .rts_o(rts1), .sow_o(sow1),
    .eow_o(eow1), .posit_o(posit1)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // checks rts/posit/sow/eow of the 4-word instance in one go
  task automatic chk_word(input string tag, input logic [3:0] w, input logic s, input logic e);
    chk({tag, "_rts"}, {15'd0, rts4}, 16'd1);
    chk({tag, "_posit"}, {12'd0, posit4}, {12'd0, w});
    chk({tag, "_sow"}, {15'd0, sow4}, {15'd0, s});
    chk({tag, "_eow"}, {15'd0, eow4}, {15'd0, e});
  endtask

  initial begin
    logic [3:0] expv;
    rts_i4 = 4'h0; eow_i4 = 4'h0; posit_i4 = 16'h0; rtr_i4 = 1'b0;
    rts_i1 = 1'b0; posit_i1 = 4'h0; rtr_i1 = 1'b0;
    #1;
    // reset values
    chk("rst_rts", {15'd0, rts4}, 16'd0);
    chk("rst_rtr", {15'd0, rtr4}, 16'd1);
    chk("rst_posit", {12'd0, posit4}, 16'd0);
    chk("rst_sow_eow", {14'd0, sow4, eow4}, 16'd0);
    step(); step();
    rst = 1'b0;
    chk("rst_partial", {15'd0, u_dut4.partial_seen}, 16'd0);

    // 1) one frame, downstream always ready
    rts_i4 = 4'hF; eow_i4 = 4'hF; posit_i4 = 16'h3210; rtr_i4 = 1'b1;
    step();
    rts_i4 = 4'h0; eow_i4 = 4'h0;
    chk_word("t1_w0", 4'h0, 1'b1, 1'b0); step();
    chk_word("t1_w1", 4'h1, 1'b0, 1'b0); step();
    chk_word("t1_w2", 4'h2, 1'b0, 1'b0); step();
    chk_word("t1_w3", 4'h3, 1'b0, 1'b1); step();
    chk("t1_idle_rts", {15'd0, rts4}, 16'd0);
    chk("t1_idle_posit", {12'd0, posit4}, 16'd0);

    // 2) same frame, downstream stalls every other cycle
    rts_i4 = 4'hF; posit_i4 = 16'h3210;
    step();
    rts_i4 = 4'h0;
    for (int w = 0; w < 4; w++) begin
      rtr_i4 = 1'b0;
      chk_word("t2_pre", 4'(w), (w == 0), (w == 3));
      step();
      chk_word("t2_hold", 4'(w), (w == 0), (w == 3));
      rtr_i4 = 1'b1;
      step();
    end
    chk("t2_idle_rts", {15'd0, rts4}, 16'd0);

    // 3) fill both banks while stalled, third frame must be refused
    rtr_i4 = 1'b0; rts_i4 = 4'hF; posit_i4 = 16'h7654;
    step();
    chk("t3_rtr_after_a", {15'd0, rtr4}, 16'd1);
    posit_i4 = 16'hBA98;
    step();
    chk("t3_rtr_full", {15'd0, rtr4}, 16'd0);
    posit_i4 = 16'hFFFF;
    step();
    rts_i4 = 4'h0;
    chk_word("t3_a_held", 4'h4, 1'b1, 1'b0);
    rtr_i4 = 1'b1;
    for (int w = 0; w < 4; w++) begin
      chk_word("t3_a", 4'(4 + w), (w == 0), (w == 3));
      chk("t3_rtr_busy", {15'd0, rtr4}, 16'd0);
      step();
    end
    chk("t3_rtr_free", {15'd0, rtr4}, 16'd1);
    for (int w = 0; w < 4; w++) begin
      chk_word("t3_b", 4'(8 + w), (w == 0), (w == 3));
      step();
    end
    chk("t3_idle_rts", {15'd0, rts4}, 16'd0);

    // 4) partial rts is never captured
    rts_i4 = 4'b0111; posit_i4 = 16'h1111;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("t4_no_cap", {15'd0, rts4}, 16'd0);
    end
    chk("t4_partial", {15'd0, u_dut4.partial_seen}, 16'd1);
    rts_i4 = 4'hF; posit_i4 = 16'hC0DE;
    step();
    rts_i4 = 4'h0;
    chk_word("t4_w0", 4'hE, 1'b1, 1'b0); step();
    chk_word("t4_w1", 4'hD, 1'b0, 1'b0); step();
    chk_word("t4_w2", 4'h0, 1'b0, 1'b0); step();
    chk_word("t4_w3", 4'hC, 1'b0, 1'b1); step();

    // 5) reset in the middle of a frame
    rts_i4 = 4'hF; posit_i4 = 16'h3210;
    step();
    rts_i4 = 4'h0;
    step(); step();
    chk_word("t5_w2", 4'h2, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_rts", {15'd0, rts4}, 16'd0);
    chk("t5_rst_rtr", {15'd0, rtr4}, 16'd1);
    chk("t5_rst_posit", {12'd0, posit4}, 16'd0);
    chk("t5_rst_partial", {15'd0, u_dut4.partial_seen}, 16'd0);
    step();
    rst = 1'b0;
    rts_i4 = 4'hF; posit_i4 = 16'h5432;
    step();
    rts_i4 = 4'h0;
    chk_word("t5_new_w0", 4'h2, 1'b1, 1'b0); step();
    chk_word("t5_new_w1", 4'h3, 1'b0, 1'b0); step(); step(); step();
    chk("t5_idle_rts", {15'd0, rts4}, 16'd0);

    // 6) one-word frames at full rate
    rtr_i1 = 1'b1; rts_i1 = 1'b1; posit_i1 = 4'hA;
    step();
    expv = 4'hA;
    for (int i = 0; i < 5; i++) begin
      chk("t6_rts", {15'd0, rts1}, 16'd1);
      chk("t6_posit", {12'd0, posit1}, {12'd0, expv});
      chk("t6_sow_eow", {14'd0, sow1, eow1}, 16'd3);
      chk("t6_rtr", {15'd0, rtr1}, 16'd1);
      posit_i1 = 4'(i);
      expv = 4'(i);
      step();
    end
    rts_i1 = 1'b0;
    chk("t6_last", {12'd0, posit1}, 16'd4);
    step();
    chk("t6_idle_rts", {15'd0, rts1}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
